rom_reader: RTL and testbench

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader_pkg.sv | 15 +
 rtl/rom_32b.sv | 12 +
 rtl/rom_reader.sv | 113 +++++++++++
 tb/tb_rom_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// rtl/rom_reader_pkg.sv - shared state encoding and default widths for the burst table reader
package rom_reader_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam int SUM_W_DEF  = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_32b.sv
// rtl/rom_32b.sv - combinational even-number lookup table, entry i holds 2*i
module rom_32b #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    assign data = DATA_W'({addr, 1'b0});

endmodule

// File: rtl/rom_reader.sv
// rtl/rom_reader.sv - burst reader: walks a combinational table, presents words
// over a valid/ready output and accumulates their sum.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  sum,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] burst_len;
    logic             handshake;
    logic             load_burst;
    logic             capture;
    logic             advance;

    assign handshake = out_valid && out_ready;

    // A count of zero requests a full sweep of the table.
    assign burst_len = (count == '0) ? CNT_W'(1 << ADDR_W) : count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_burst = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load_burst = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                capture    = 1'b1;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    advance    = 1'b1;
                    state_next = (remaining == CNT_W'(1)) ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            if (load_burst) begin
                rom_addr  <= base_addr;
                remaining <= burst_len;
                sum       <= '0;
            end
            if (capture) begin
                out_data  <= rom_data;
                out_addr  <= rom_addr;
                sum       <= sum + SUM_W'(rom_data);
                out_valid <= 1'b1;
            end
            // Address wraps naturally at the table size.
            if (advance) begin
                out_valid <= 1'b0;
                rom_addr  <= rom_addr + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_rom_reader.sv
// tb/tb_rom_reader.sv - scoreboard bench for rom_reader driven by the even-number table
module tb_rom_reader;
    import rom_reader_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int DW = DATA_W_DEF;
    localparam int SW = SUM_W_DEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SW-1:0] sum;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    rom_reader #(.ADDR_W(AW), .DATA_W(DW), .SUM_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_addr(out_addr),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .busy(busy), .done(done)
    );

    rom_32b #(.ADDR_W(AW), .DATA_W(DW)) u_rom (.addr(rom_addr), .data(rom_data));

    typedef struct {
        int addr;
        int data;
    } word_t;

    word_t exp_q[$];
    word_t w;
    int    checks = 0;
    int    errors = 0;
    int    acc_cnt = 0;
    int    done_cnt = 0;
    int    exp_sum = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 1, 0);
            end else begin
                w = exp_q.pop_front();
                check("out_addr", int'(out_addr), w.addr);
                check("out_data", int'(out_data), w.data);
            end
            acc_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic wait_acc(input int k);
        int t = 0;
        while (acc_cnt < k && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("acc_timeout", int'(acc_cnt >= k), 1);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("valid_timeout", int'(out_valid), 1);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    task automatic load_expect(input int base, input int cnt);
        int n = (cnt == 0) ? 8 : cnt;
        int a;
        exp_sum = 0;
        for (int i = 0; i < n; i++) begin
            a = (base + i) % 8;
            exp_q.push_back('{a, 2 * a});
            exp_sum += 2 * a;
        end
    endtask

    task automatic issue_start(input int base, input int cnt);
        @(posedge clk); #1;
        base_addr = AW'(base);
        count     = (AW + 1)'(cnt);
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = AW'(7);
        count     = (AW + 1)'(1);
        check("busy_after_start", int'(busy), 1);
        check("valid_after_start", int'(out_valid), 0);
    endtask

    task automatic burst(input int base, input int cnt, input int stall_idx,
                         input int stall_cyc, input bit poke);
        int n = (cnt == 0) ? 8 : cnt;
        acc_cnt  = 0;
        done_cnt = 0;
        load_expect(base, cnt);
        issue_start(base, cnt);
        if (stall_idx > 0) begin
            wait_acc(stall_idx);
            @(posedge clk); #1;
            out_ready = 1'b0;
            wait_valid();
            repeat (stall_cyc) begin
                @(negedge clk);
                check("stall_valid", int'(out_valid), 1);
                check("stall_addr", int'(out_addr), exp_q[0].addr);
                check("stall_data", int'(out_data), exp_q[0].data);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        if (poke) begin
            wait_acc(1);
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_done();
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("busy_idle", int'(busy), 0);
        check("done_pulses", done_cnt, 1);
        check("words_accepted", acc_cnt, n);
        check("queue_empty", exp_q.size(), 0);
        check("sum", int'(sum), exp_sum);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_out_data"}, int'(out_data), 0);
        check({tag, "_out_addr"}, int'(out_addr), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        burst(0, 8, -1, 0, 1'b0);
        check("sum_full_sweep", int'(sum), 56);
        burst(6, 4, -1, 0, 1'b0);
        check("sum_wrap", int'(sum), 28);
        burst(3, 0, -1, 0, 1'b0);
        check("sum_count_zero", int'(sum), 56);
        burst(1, 3, 1, 5, 1'b0);
        burst(2, 3, -1, 0, 1'b1);
        check("sum_after_pokes", int'(sum), 18);
        repeat (4) @(negedge clk);
        check("sum_holds", int'(sum), 18);

        acc_cnt  = 0;
        done_cnt = 0;
        load_expect(0, 5);
        issue_start(0, 5);
        wait_acc(2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midburst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("no_done_on_reset", done_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        burst(5, 1, -1, 0, 1'b0);
        check("sum_after_reset", int'(sum), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
